fixed_point_addsub_pipe: RTL and testbench
==========================================

# fixed_point_addsub_pipe

Multi-lane, pipelined adder/subtractor for sign-magnitude Q-format fixed-point values. It adds or subtracts per lane and saturates on overflow. Negative zero is normalised to positive zero. Each lane reports overflow, and a sticky overflow status is kept. It sits between fixed-point producers and consumers on a valid/ready stream and replaces ad-hoc combinational adders where throughput and backpressure matter.

## Interface
- N, 16, total word width incl. sign bit (N >= 3)
- Q, 8, fractional bits (Q <= N-2); does not alter arithmetic, documents format
- LANES, 1, independent parallel lanes sharing one handshake
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  LANES*N  operand A, lane k at [k*N +: N]
- in_b  in  LANES*N  operand B, same packing
- in_op  in  LANES  per-lane op: 0 = A+B, 1 = A-B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_c  out  LANES*N  result, same packing
- out_ovf  out  LANES  per-lane saturation flag, qualified by out_valid
- ovf_sticky  out  1  OR of all out_ovf bits transferred since last clear
- ovf_clr  in  1  clears ovf_sticky

## Operation
- Word format: bit N-1 is the sign (1 = negative); bits N-2:0 are the unsigned magnitude with Q fractional bits. Max magnitude M = 2^(N-1)-1.
- Input 1...0 (negative zero) is treated as +0.
- Subtract: the effective sign of B is inverted; then the add rule applies.
- Same effective signs: magnitude = |A|+|B| computed N bits wide; if > M, the result is sign with magnitude M and ovf=1; otherwise the sum is used and ovf=0.
- Differing signs: the result is the larger magnitude minus the smaller, with the sign of the larger; ovf=0 always.
- Zero result magnitude always yields sign 0; out_c is never negative zero.
- Stage 1: normalise negative zero, apply op, compare magnitudes, swap operands into (big, small), record result sign and add/sub mode.
- Stage 2: add or subtract, saturate, normalise sign, register into out_c/out_ovf.
- Lanes are fully independent in data; they share in_valid/in_ready/out_valid/out_ready.
- ovf_sticky sets on any output transfer (out_valid & out_ready) with any out_ovf bit high. If ovf_clr and such a transfer occur in the same cycle, set wins.

## Timing
- Transfer happens on valid & ready at the rising edge of clk.
- Latency is 2 cycles: operands accepted at edge t produce out_valid at edge t+2 when there is no stall.
- Throughput is one operand set per cycle while out_ready is high.
- Stage 2 loads when !out_valid | out_ready. Stage 1 loads when stage 1 is empty or stage 2 loads.
- in_ready = !s1_valid | stage-2-load. It is combinational from out_ready; there is no skid buffer.
- out_valid held high with out_ready low: out_c and out_ovf stay stable until transfer.
- A stalled pipeline holds at most 2 operand sets. in_ready falls when both stages are full and out_ready is low.
- Reset: out_valid=0, s1_valid=0, out_c=0, out_ovf=0, ovf_sticky=0. in_ready is 1 in the cycle after reset release. Reset mid-operation discards in-flight data without emitting it.
- in_valid while in_ready is low: the operands are not captured, and the producer must hold them.

## Structure
- Package fixed_point_pkg holds OP_ADD=1'b0 and OP_SUB=1'b1, plus a function sm_max_mag(N) returning the saturation magnitude.
- Sub-module fixed_point_addsub_lane: the two-stage datapath for one lane. It has stage enables and no handshake logic and is instantiated LANES times with a generate loop.
- The top level owns the valid bits, the ready logic and ovf_sticky.

## Test plan
- N=16, Q=8, op=0: 0x0180 + 0x8080 (1.5 + -0.5) -> 0x0100, ovf=0, out_valid two cycles after acceptance.
- op=0: 0x7F00 + 0x0200 -> 0x7FFF, ovf=1, ovf_sticky=1 after transfer; then 0xFF00 + 0x8200 -> 0xFFFF, ovf=1.
- op=1: 0x0080 - 0x0080 -> 0x0000, not 0x8000. op=0: 0x8000 + 0x8000 -> 0x0000. op=1: 0x0100 - 0x0300 -> 0x8200.
- Hold out_ready low for 5 cycles with in_valid high: exactly 2 sets accepted and in_ready goes low. On release, results drain in order, one per cycle, with no loss or duplication.
- LANES=2: lane0 0x7FFF + 0x0001 (ovf), lane1 0x0010 + 0x0020 -> out_ovf=2'b01 and lane1=0x0030. Assert ovf_clr: sticky clears, except when it coincides with an overflowing transfer.
- Assert rst with both stages full: next cycle out_valid=0, out_c=0, ovf_sticky=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/fixed_point_addsub_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared definitions for the sign-magnitude fixed-point add/sub pipeline:
//   OP_ADD / OP_SUB : per-lane operation encodings
//   sm_max_mag(n)   : largest magnitude representable in an n-bit
//                     sign-magnitude word (2^(n-1) - 1), used for saturation
// -----------------------------------------------------------------------------
package fixed_point_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic logic [31:0] sm_max_mag(input int unsigned n);
      return (32'd1 << (n - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/fixed_point_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// fixed_point_addsub_pipe_if
// Groups the operand stream, result stream and overflow status of the
// add/sub pipeline.
//   master : the environment (drives operands, out_ready, ovf_clr)
//   slave  : the pipeline   (drives in_ready, results, ovf_sticky)
// Lane k of every packed bus lives at [k*N +: N].
// -----------------------------------------------------------------------------
interface fixed_point_addsub_pipe_if #(
   parameter int N     = 16,
   parameter int LANES = 1
);
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*N-1:0]   in_a;
   logic [LANES*N-1:0]   in_b;
   logic [LANES-1:0]     in_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*N-1:0]   out_c;
   logic [LANES-1:0]     out_ovf;
   logic                 ovf_sticky;
   logic                 ovf_clr;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready, ovf_clr,
      input  in_ready, out_valid, out_c, out_ovf, ovf_sticky
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready, ovf_clr,
      output in_ready, out_valid, out_c, out_ovf, ovf_sticky
   );
endinterface

// File: rtl/fixed_point_addsub_lane.sv
// -----------------------------------------------------------------------------
// fixed_point_addsub_lane
// Two-stage sign-magnitude add/sub datapath for one lane; no handshake logic.
//   clk, rst   : clock, synchronous active-high reset
//   s1_en_i    : load stage 1 from a_i/b_i/op_i
//   s2_en_i    : load stage 2 (c_o/ovf_o) from stage 1
//   a_i, b_i   : sign-magnitude operands
//   op_i       : OP_ADD (A+B) or OP_SUB (A-B)
//   c_o        : saturated, zero-normalised result
//   ovf_o      : result was saturated
// -----------------------------------------------------------------------------
module fixed_point_addsub_lane
   import fixed_point_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s1_en_i,
   input  logic         s2_en_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         op_i,
   output logic [N-1:0] c_o,
   output logic         ovf_o
);
   localparam int            MW      = N - 1;
   localparam logic [MW-1:0] MAX_MAG = MW'(sm_max_mag(N));

   logic [MW-1:0] big_d, big_q, small_d, small_q;
   logic          sign_d, sign_q, sub_d, sub_q;
   logic [MW-1:0] mag_a_s, mag_b_s, mag_s;
   logic          sign_a_s, sign_b_s, a_big_s, ovf_s;
   logic [N-1:0]  sum_s, c_d;
   logic [MW-1:0] diff_s;

   // Stage 1: drop negative zero, fold op into B's sign, order by magnitude
   always_comb begin
      mag_a_s  = a_i[MW-1:0];
      mag_b_s  = b_i[MW-1:0];
      sign_a_s = a_i[N-1] & (mag_a_s != {MW{1'b0}});
      sign_b_s = (b_i[N-1] & (mag_b_s != {MW{1'b0}})) ^ (op_i == OP_SUB);
      a_big_s  = (mag_a_s >= mag_b_s);
      big_d    = a_big_s ? mag_a_s : mag_b_s;
      small_d  = a_big_s ? mag_b_s : mag_a_s;
      // the larger operand's sign wins; equal-magnitude cancellation is fixed up in stage 2
      sign_d   = a_big_s ? sign_a_s : sign_b_s;
      sub_d    = sign_a_s ^ sign_b_s;
   end

   // Stage 1 registers
   always_ff @(posedge clk) begin
      if (rst) begin
         big_q   <= {MW{1'b0}};
         small_q <= {MW{1'b0}};
         sign_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else if (s1_en_i) begin
         big_q   <= big_d;
         small_q <= small_d;
         sign_q  <= sign_d;
         sub_q   <= sub_d;
      end else begin
         big_q   <= big_q;
         small_q <= small_q;
         sign_q  <= sign_q;
         sub_q   <= sub_q;
      end
   end

   // Stage 2: magnitude add with saturation or ordered subtract, then zero-normalise sign
   always_comb begin
      sum_s  = {1'b0, big_q} + {1'b0, small_q};
      diff_s = big_q - small_q;
      if (sub_q) begin
         mag_s = diff_s;
         ovf_s = 1'b0;
      end else if (sum_s > {1'b0, MAX_MAG}) begin
         mag_s = MAX_MAG;
         ovf_s = 1'b1;
      end else begin
         mag_s = sum_s[MW-1:0];
         ovf_s = 1'b0;
      end
      c_d = {sign_q & (mag_s != {MW{1'b0}}), mag_s};
   end

   // Stage 2 registers drive the outputs directly
   always_ff @(posedge clk) begin
      if (rst) begin
         c_o   <= {N{1'b0}};
         ovf_o <= 1'b0;
      end else if (s2_en_i) begin
         c_o   <= c_d;
         ovf_o <= ovf_s;
      end else begin
         c_o   <= c_o;
         ovf_o <= ovf_o;
      end
   end
endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fixed_point_addsub_pipe
// Multi-lane, two-stage pipelined sign-magnitude adder/subtractor with
// saturation on a valid/ready stream.
//   clk  : clock
//   rst  : synchronous active-high reset; discards in-flight data
//   bus  : slave side of fixed_point_addsub_pipe_if (operands, results,
//          per-lane overflow, sticky overflow and its clear)
// Lanes are independent in data and share one handshake. in_ready depends
// combinationally on out_ready (no skid buffer).
// -----------------------------------------------------------------------------
module fixed_point_addsub_pipe
   import fixed_point_pkg::*;
#(
   parameter int N     = 16,
   parameter int Q     = 8,
   parameter int LANES = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   fixed_point_addsub_pipe_if.slave    bus
);
   if (N < 3 || Q > N - 2 || LANES < 1) begin : g_param_check
      $error("fixed_point_addsub_pipe: illegal N/Q/LANES combination");
   end

   logic s1_valid_d, s1_valid_q;
   logic out_valid_d, out_valid_q;
   logic sticky_d, sticky_q;
   logic s1_load_s, s2_load_s, s1_en_s, s2_en_s;

   // Handshake, stage enables and next-state of the valid bits / sticky flag
   always_comb begin
      s2_load_s   = ~out_valid_q | bus.out_ready;
      s1_load_s   = ~s1_valid_q | s2_load_s;
      s1_en_s     = bus.in_valid & s1_load_s;
      s2_en_s     = s1_valid_q & s2_load_s;
      s1_valid_d  = s1_load_s ? bus.in_valid : s1_valid_q;
      out_valid_d = s2_load_s ? s1_valid_q : out_valid_q;
      // a transfer carrying overflow beats a simultaneous clear
      if (out_valid_q & bus.out_ready & (|bus.out_ovf)) begin
         sticky_d = 1'b1;
      end else if (bus.ovf_clr) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         sticky_q    <= sticky_d;
      end
   end

   assign bus.in_ready   = s1_load_s;
   assign bus.out_valid  = out_valid_q;
   assign bus.ovf_sticky = sticky_q;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      fixed_point_addsub_lane #(.N(N)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .s1_en_i (s1_en_s),
         .s2_en_i (s2_en_s),
         .a_i     (bus.in_a[k*N +: N]),
         .b_i     (bus.in_b[k*N +: N]),
         .op_i    (bus.in_op[k]),
         .c_o     (bus.out_c[k*N +: N]),
         .ovf_o   (bus.out_ovf[k])
      );
   end
endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_addsub_pipe
// Self-checking bench: directed scenarios followed by random traffic, with
// results checked against an integer-arithmetic reference and a scoreboard.
// -----------------------------------------------------------------------------
module tb_fixed_point_addsub_pipe;
   import fixed_point_pkg::*;

   localparam int N     = 16;
   localparam int Q     = 8;
   localparam int LANES = 2;
   localparam int W     = N * LANES;
   localparam int MW    = N - 1;

   typedef struct packed {
      logic [W-1:0]     c;
      logic [LANES-1:0] ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fixed_point_addsub_pipe_if #(.N(N), .LANES(LANES)) bus ();

   fixed_point_addsub_pipe #(.N(N), .Q(Q), .LANES(LANES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   res_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic sticky_m = 1'b0;
   int   acc_cnt = 0;
   int   out_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer sum of the two lane values, clamped to +/-max
   function automatic res_t ref_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [LANES-1:0] op);
      res_t r;
      int   va, vb, s, m;
      m = (1 << (N - 1)) - 1;
      for (int k = 0; k < LANES; k++) begin
         va = int'(a[k*N +: MW]);
         if (a[k*N + N - 1]) va = -va;
         vb = int'(b[k*N +: MW]);
         if (b[k*N + N - 1]) vb = -vb;
         if (op[k]) vb = -vb;
         s = va + vb;
         r.ovf[k] = 1'b0;
         if (s > m) begin
            s = m;
            r.ovf[k] = 1'b1;
         end else if (s < -m) begin
            s = -m;
            r.ovf[k] = 1'b1;
         end
         r.c[k*N +: N] = (s < 0) ? {1'b1, MW'(-s)} : {1'b0, MW'(s)};
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rnd_word();
      logic [N-1:0]  w;
      logic [MW-1:0] mx;
      mx = {MW{1'b1}};
      w  = N'($urandom);
      case ($urandom_range(3, 0))
         0:       w[MW-1:0] = mx - MW'($urandom_range(3, 0));
         1:       w[MW-1:0] = {MW{1'b0}};
         default: w = w;
      endcase
      return w;
   endfunction

   function automatic logic [W-1:0] rnd_vec();
      logic [W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*N +: N] = rnd_word();
      return v;
   endfunction

   // One cycle: check sticky, drive at negedge, score what will transfer at the next edge
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [LANES-1:0] op, input logic ordy, input logic clr);
      res_t e;
      logic xfer_ovf;
      @(negedge clk);
      chk("ovf_sticky", bus.ovf_sticky, sticky_m);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.out_ready = ordy;
      bus.ovf_clr   = clr;
      #1;
      xfer_ovf = 1'b0;
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", bus.out_valid, 1'b0);
         end else begin
            chk("out_c", bus.out_c, exp_q[0].c);
            chk("out_ovf", bus.out_ovf, exp_q[0].ovf);
            if (ordy) begin
               e = exp_q.pop_front();
               out_cnt++;
               xfer_ovf = |e.ovf;
            end
         end
      end
      if (xfer_ovf) sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
      if (v && bus.in_ready === 1'b1) begin
         exp_q.push_back(ref_vec(a, b, op));
         acc_cnt++;
      end
   endtask

   task automatic idle(input logic ordy, input logic clr);
      step(1'b0, {W{1'b0}}, {W{1'b0}}, {LANES{1'b0}}, ordy, clr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.ovf_clr   = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_c", bus.out_c, {W{1'b0}});
      chk("rst_out_ovf", bus.out_ovf, {LANES{1'b0}});
      chk("rst_ovf_sticky", bus.ovf_sticky, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      sticky_m = 1'b0;
      @(negedge clk);
      #1;
      chk("in_ready_after_rst", bus.in_ready, 1'b1);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = {W{1'b0}};
      bus.in_b      = {W{1'b0}};
      bus.in_op     = {LANES{1'b0}};
      bus.out_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // latency: 1.5 + -0.5 = 1.0, valid two edges after acceptance
      step(1'b1, {16'h0000, 16'h0180}, {16'h0000, 16'h8080}, 2'b00, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      chk("latency_edge1_not_valid", bus.out_valid, 1'b0);
      idle(1'b1, 1'b0);
      chk("latency_edge2_valid", bus.out_valid, 1'b1);
      chk("basic_sum_lane0", bus.out_c[15:0], 16'h0100);

      // saturation, negative zero, sign handling, two-lane independence
      step(1'b1, {16'h0010, 16'h7F00}, {16'h0020, 16'h0200}, 2'b00, 1'b1, 1'b0);
      step(1'b1, {16'h0000, 16'hFF00}, {16'h0000, 16'h8200}, 2'b00, 1'b1, 1'b0);
      step(1'b1, {16'h0000, 16'h0080}, {16'h0000, 16'h0080}, 2'b01, 1'b1, 1'b0);
      step(1'b1, {16'h8000, 16'h8000}, {16'h8000, 16'h8000}, 2'b00, 1'b1, 1'b0);
      step(1'b1, {16'h8000, 16'h0100}, {16'h0000, 16'h0300}, 2'b11, 1'b1, 1'b0);
      step(1'b1, {16'h0010, 16'h7FFF}, {16'h0020, 16'h0001}, 2'b00, 1'b1, 1'b0);
      repeat (3) idle(1'b1, 1'b0);
      chk("sticky_after_ovf", bus.ovf_sticky, 1'b1);

      // clear without a coinciding overflow
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      chk("sticky_cleared", bus.ovf_sticky, 1'b0);

      // clear coinciding with an overflowing transfer: set wins
      step(1'b1, {16'h0010, 16'h7FFF}, {16'h0020, 16'h0001}, 2'b00, 1'b1, 1'b0);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      chk("sticky_set_wins", bus.ovf_sticky, 1'b1);

      // backpressure: 5 cycles of in_valid with out_ready low
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) step(1'b1, rnd_vec(), rnd_vec(), 2'($urandom), 1'b0, 1'b0);
      chk("stall_accepted", acc_cnt, 2);
      chk("stall_in_ready_low", bus.in_ready, 1'b0);
      out_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         idle(1'b1, 1'b0);
         chk("drain_valid", bus.out_valid, 1'b1);
      end
      idle(1'b1, 1'b0);
      chk("drain_count", out_cnt, 2);
      chk("drain_empty", exp_q.size(), 0);

      // reset with both stages full discards everything
      for (int i = 0; i < 3; i++)
         step(1'b1, {16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF}, 2'b00, 1'b0, 1'b0);
      do_reset();
      repeat (4) idle(1'b1, 1'b0);
      chk("no_stale_after_rst", bus.out_valid, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(3, 0) != 0), rnd_vec(), rnd_vec(), 2'($urandom),
              ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) == 0));
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1, 1'b0);
      chk("random_drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
